// File: rtl/instruction_fetch_mem.sv
// Clocked instruction memory between the PC/fetch stage and decode.
// Latency: LATENCY cycles (1..4) from request accept to response; streams one response per cycle.
// Backpressure: rsp_valid & !rsp_ready freezes every stage and drops req_ready; flush/reset discard in-flight work.
//
// Ports:
//   clock, reset (sync, active-high), flush (drop everything in flight)
//   req_valid/req_ready/req_addr          : byte-addressed fetch request
//   rsp_valid/rsp_ready/rsp_instr/rsp_addr/rsp_fault : fetched word, its address, bad-address tag
//   load_we/load_index/load_data          : write port, present only when IMEM_LOAD_EN is defined
// Optional feature macro: IMEM_LOAD_EN (adds the write port; otherwise read-only).
module instruction_fetch_mem #(
  parameter int    XLEN      = 32,
  parameter int    DEPTH     = 256,
  parameter int    ADDR_W    = 32,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = "program.txt"
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [XLEN-1:0]          rsp_instr,
  output logic [ADDR_W-1:0]        rsp_addr,
  output logic                     rsp_fault
`ifdef IMEM_LOAD_EN
  ,
  input  logic                     load_we,
  input  logic [$clog2(DEPTH)-1:0] load_index,
  input  logic [XLEN-1:0]          load_data
`endif
);

  localparam int              IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [XLEN-1:0] NOP   = XLEN'(32'h0000_0013);  // addi x0, x0, 0

  if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
    $error("instruction_fetch_mem: LATENCY must be in 1..4");
  end

  logic [XLEN-1:0] mem [DEPTH];

  // Pipeline stages; index LATENCY-1 is the one presented on rsp_*.
  logic              stg_vld   [LATENCY];
  logic [ADDR_W-1:0] stg_addr  [LATENCY];
  logic [XLEN-1:0]   stg_instr [LATENCY];
  logic              stg_fault [LATENCY];

  logic              advance;
  logic              accept;
  logic [63:0]       word_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              fetch_fault;
  logic [XLEN-1:0]   fetch_instr;

  // Full-width index compare so addresses beyond the array fault instead of aliasing.
  assign word_idx    = 64'(req_addr[ADDR_W-1:2]);
  assign rd_idx      = req_addr[IDX_W+1:2];
  assign fetch_fault = (req_addr[1:0] != 2'b00) | (word_idx >= 64'(DEPTH));
  // A faulting address never indexes the array; it carries a NOP instead.
  assign fetch_instr = fetch_fault ? NOP : mem[rd_idx];

  // The pipe moves as a whole whenever the presented slot is empty or being taken.
  assign advance   = !stg_vld[LATENCY-1] | rsp_ready;
  assign req_ready = advance & !flush & !reset;
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < LATENCY; i++) begin
        stg_vld[i]   <= 1'b0;
        stg_addr[i]  <= '0;
        stg_instr[i] <= NOP;
        stg_fault[i] <= 1'b0;
      end
    end else if (flush) begin
      // Drops everything, including a response handed over this same cycle.
      for (int i = 0; i < LATENCY; i++) begin
        stg_vld[i] <= 1'b0;
      end
    end else if (advance) begin
      stg_vld[0]   <= accept;
      stg_addr[0]  <= req_addr;
      stg_instr[0] <= fetch_instr;
      stg_fault[0] <= fetch_fault;
      for (int i = 1; i < LATENCY; i++) begin
        stg_vld[i]   <= stg_vld[i-1];
        stg_addr[i]  <= stg_addr[i-1];
        stg_instr[i] <= stg_instr[i-1];
        stg_fault[i] <= stg_fault[i-1];
      end
    end
  end

`ifdef IMEM_LOAD_EN
  // Write port ignores reset/flush. Stage 0 samples the array before this write
  // lands, so a same-cycle fetch of the written index sees the old word.
  always_ff @(posedge clock) begin
    if (load_we) mem[load_index] <= load_data;
  end
`endif

  assign rsp_valid = stg_vld[LATENCY-1];
  assign rsp_addr  = stg_addr[LATENCY-1];
  assign rsp_instr = stg_instr[LATENCY-1];
  assign rsp_fault = stg_fault[LATENCY-1];

endmodule

// File: tb/tb_instruction_fetch_mem.sv
// Bench for instruction_fetch_mem: three instances with LATENCY 1, 2 and 3.
// Instance 0 runs a table of per-cycle vectors; instances 1 and 2 run flush and stall sequences.
module tb_instruction_fetch_mem;

  localparam int          DEPTH = 16;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst [3];
  logic        fl  [3];
  logic        rv  [3];
  logic        rr  [3];
  logic [31:0] ra  [3];
  logic        rsv [3];
  logic        rsr [3];
  logic [31:0] ri  [3];
  logic [31:0] rad [3];
  logic        flt [3];
`ifdef IMEM_LOAD_EN
  logic        lw  [3];
  logic [3:0]  li  [3];
  logic [31:0] ld  [3];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Memory image: word k holds C0DE_0000 + k*0x101.
  function automatic logic [31:0] img(input int k);
    return 32'hC0DE_0000 + 32'(k) * 32'h0000_0101;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    instruction_fetch_mem #(
      .XLEN(32), .DEPTH(DEPTH), .ADDR_W(32), .LATENCY(g + 1), .INIT_FILE("")
    ) u_dut (
      .clock(clk), .reset(rst[g]), .flush(fl[g]),
      .req_valid(rv[g]), .req_ready(rr[g]), .req_addr(ra[g]),
      .rsp_valid(rsv[g]), .rsp_ready(rsr[g]), .rsp_instr(ri[g]),
      .rsp_addr(rad[g]), .rsp_fault(flt[g])
`ifdef IMEM_LOAD_EN
      ,
      .load_we(lw[g]), .load_index(li[g]), .load_data(ld[g])
`endif
    );
`ifndef IMEM_LOAD_EN
    initial for (int k = 0; k < DEPTH; k++) u_dut.mem[k] = img(k);
`endif
  end

  typedef struct {
    logic        r, f, v;
    logic [31:0] a;
    logic        rs;
    logic        e_rdy, e_vld, e_pay;
    logic [31:0] e_instr, e_addr;
    logic        e_flt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic f, input logic v,
                              input logic [31:0] a, input logic rs,
                              input logic e_rdy, input logic e_vld, input logic e_pay,
                              input logic [31:0] e_instr, input logic [31:0] e_addr,
                              input logic e_flt);
    vec_t t;
    t.r = r; t.f = f; t.v = v; t.a = a; t.rs = rs;
    t.e_rdy = e_rdy; t.e_vld = e_vld; t.e_pay = e_pay;
    t.e_instr = e_instr; t.e_addr = e_addr; t.e_flt = e_flt;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int u, input logic r, input logic f, input logic v,
                       input logic [31:0] a, input logic rs);
    rst[u] = r; fl[u] = f; rv[u] = v; ra[u] = a; rsr[u] = rs;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  localparam int NV = 19;
  vec_t tbl [NV];

  initial begin : main
    int          nacc, nrx;
    logic        stalled_prev;
    logic [31:0] hold_i, hold_a;
    logic        hold_f;

    for (int u = 0; u < 3; u++) begin
      drive(u, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
`ifdef IMEM_LOAD_EN
      lw[u] = 1'b0; li[u] = 4'd0; ld[u] = 32'h0;
`endif
    end

    //              r  f  v  addr      rs   rdy vld pay instr         addr      flt
    tbl[0]  = mk(1, 0, 0, 32'h00, 1,   0,  0,  1,  NOP,          32'h00, 0); // reset state
    tbl[1]  = mk(0, 0, 1, 32'h00, 1,   1,  0,  1,  NOP,          32'h00, 0);
    tbl[2]  = mk(0, 0, 1, 32'h04, 1,   1,  1,  1,  32'hC0DE0000, 32'h00, 0);
    tbl[3]  = mk(0, 0, 1, 32'h08, 1,   1,  1,  1,  32'hC0DE0101, 32'h04, 0);
    tbl[4]  = mk(0, 0, 1, 32'h06, 1,   1,  1,  1,  32'hC0DE0202, 32'h08, 0);
    tbl[5]  = mk(0, 0, 1, 32'h40, 1,   1,  1,  1,  NOP,          32'h06, 1); // misaligned
    tbl[6]  = mk(0, 0, 1, 32'h3C, 1,   1,  1,  1,  NOP,          32'h40, 1); // index == DEPTH
    tbl[7]  = mk(0, 0, 0, 32'h00, 0,   0,  1,  1,  32'hC0DE0F0F, 32'h3C, 0); // last word, stall
    tbl[8]  = mk(0, 0, 1, 32'h0C, 0,   0,  1,  1,  32'hC0DE0F0F, 32'h3C, 0); // held
    tbl[9]  = mk(0, 0, 1, 32'h0C, 1,   1,  1,  1,  32'hC0DE0F0F, 32'h3C, 0); // consume + accept
    tbl[10] = mk(0, 0, 0, 32'h0C, 1,   1,  1,  1,  32'hC0DE0303, 32'h0C, 0);
    tbl[11] = mk(0, 0, 1, 32'h10, 0,   1,  0,  0,  NOP,          32'h00, 0); // empty: ready
    tbl[12] = mk(0, 0, 1, 32'h14, 0,   0,  1,  1,  32'hC0DE0404, 32'h10, 0);
    tbl[13] = mk(1, 0, 1, 32'h14, 1,   0,  1,  1,  32'hC0DE0404, 32'h10, 0); // reset mid-stream
    tbl[14] = mk(0, 0, 0, 32'h00, 1,   1,  0,  1,  NOP,          32'h00, 0);
    tbl[15] = mk(0, 1, 1, 32'h00, 1,   0,  0,  0,  NOP,          32'h00, 0); // flush blocks accept
    tbl[16] = mk(0, 0, 1, 32'h04, 1,   1,  0,  0,  NOP,          32'h00, 0);
    tbl[17] = mk(0, 1, 1, 32'h08, 1,   0,  1,  1,  32'hC0DE0101, 32'h04, 0); // flush drops it
    tbl[18] = mk(0, 0, 0, 32'h00, 1,   1,  0,  0,  NOP,          32'h00, 0);

`ifdef IMEM_LOAD_EN
    for (int k = 0; k < DEPTH; k++) begin
      @(posedge clk); #1;
      for (int u = 0; u < 3; u++) begin
        lw[u] = 1'b1; li[u] = 4'(k); ld[u] = img(k);
      end
    end
    @(posedge clk); #1;
    for (int u = 0; u < 3; u++) lw[u] = 1'b0;
`else
    repeat (2) @(posedge clk);
`endif

    // ---- Instance 0 (LATENCY=1): vector table ----
    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(0, tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].a, tbl[i].rs);
      @(negedge clk);
      chk($sformatf("v%0d.req_ready", i), 32'(rr[0]), 32'(tbl[i].e_rdy));
      chk($sformatf("v%0d.rsp_valid", i), 32'(rsv[0]), 32'(tbl[i].e_vld));
      if (tbl[i].e_pay) begin
        chk($sformatf("v%0d.rsp_instr", i), ri[0], tbl[i].e_instr);
        chk($sformatf("v%0d.rsp_addr", i), rad[0], tbl[i].e_addr);
        chk($sformatf("v%0d.rsp_fault", i), 32'(flt[0]), 32'(tbl[i].e_flt));
      end
    end

`ifdef IMEM_LOAD_EN
    // ---- Instance 0: write mem[2] while fetching 0x8 the same cycle ----
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b1, 32'h08, 1'b1);
    lw[0] = 1'b1; li[0] = 4'd2; ld[0] = 32'hDEADBEEF;
    @(posedge clk); #1;
    lw[0] = 1'b0;
    @(negedge clk);
    chk("ld.old_valid", 32'(rsv[0]), 32'd1);
    chk("ld.old_instr", ri[0], 32'hC0DE0202);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1);
    @(negedge clk);
    chk("ld.new_instr", ri[0], 32'hDEADBEEF);
    chk("ld.new_addr", rad[0], 32'h08);
`endif

    // ---- Instance 1 (LATENCY=2): two in flight, flush, then fetch 0x10 ----
    @(posedge clk); #1; drive(1, 1'b0, 1'b0, 1'b1, 32'h00, 1'b1);
    @(negedge clk); chk("fl.acc0", 32'(rr[1]), 32'd1);
    @(posedge clk); #1; drive(1, 1'b0, 1'b0, 1'b1, 32'h04, 1'b1);
    @(negedge clk); chk("fl.acc1", 32'(rr[1]), 32'd1);
    @(posedge clk); #1; drive(1, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1);
    @(negedge clk);
    chk("fl.presented", 32'(rsv[1]), 32'd1);
    chk("fl.ready_low", 32'(rr[1]), 32'd0);
    @(posedge clk); #1; drive(1, 1'b0, 1'b0, 1'b1, 32'h10, 1'b1);
    @(negedge clk);
    chk("fl.gone0", 32'(rsv[1]), 32'd0);
    chk("fl.ready_back", 32'(rr[1]), 32'd1);
    @(posedge clk); #1; drive(1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b1);
    @(negedge clk); chk("fl.gone1", 32'(rsv[1]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("fl.rsp_valid", 32'(rsv[1]), 32'd1);
    chk("fl.rsp_instr", ri[1], 32'hC0DE0404);
    chk("fl.rsp_addr", rad[1], 32'h10);
    chk("fl.rsp_fault", 32'(flt[1]), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("fl.after", 32'(rsv[1]), 32'd0);

    // ---- Instance 2 (LATENCY=3): 5 streamed requests, rsp_ready low 4 cycles ----
    nacc = 0; nrx = 0; stalled_prev = 1'b0;
    hold_i = '0; hold_a = '0; hold_f = 1'b0;
    for (int c = 0; c < 30; c++) begin
      logic rs_c, v_c;
      rs_c = !(c >= 4 && c < 8);
      v_c  = (nacc < 5);
      @(posedge clk); #1;
      drive(2, 1'b0, 1'b0, v_c, 32'(nacc * 4), rs_c);
      @(negedge clk);
      if (v_c && rr[2]) nacc++;
      if (rsv[2] && rs_c) begin
        if (nrx >= 5) begin
          checks++; failures++;
          $display("FAIL st.extra: got response addr %h after all 5 delivered", rad[2]);
        end else begin
          chk($sformatf("st.instr%0d", nrx), ri[2], img(nrx));
          chk($sformatf("st.addr%0d", nrx), rad[2], 32'(nrx * 4));
          chk($sformatf("st.fault%0d", nrx), 32'(flt[2]), 32'd0);
        end
        nrx++;
      end else if (rsv[2]) begin
        chk($sformatf("st.ready_c%0d", c), 32'(rr[2]), 32'd0);
        if (stalled_prev) begin
          chk($sformatf("st.hold_instr_c%0d", c), ri[2], hold_i);
          chk($sformatf("st.hold_addr_c%0d", c), rad[2], hold_a);
          chk($sformatf("st.hold_fault_c%0d", c), 32'(flt[2]), 32'(hold_f));
        end
        hold_i = ri[2]; hold_a = rad[2]; hold_f = flt[2];
      end
      stalled_prev = rsv[2] && !rs_c;
    end
    chk("st.count", 32'(nrx), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
